// File: rtl/uart_prot_pkg.sv
// Shared encodings for the UART protocol-layer TX sequencer.
package uart_prot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_STOP = 3'd4
  } state_e;

  // Frame-select codes for the CFG-side TX mux.
  localparam logic [1:0] TXSEL_ADDR = 2'd0;
  localparam logic [1:0] TXSEL_DATA = 2'd1;
  localparam logic [1:0] TXSEL_STOP = 2'd2;
  localparam logic [1:0] TXSEL_CSUM = 2'd3;

endpackage

// File: rtl/uart_cts_sync.sv
// Two-flop synchroniser for the asynchronous clear-to-send input, resets to 0.
module uart_cts_sync (
  input  logic glb_clk,
  input  logic glb_rstn,
  input  logic raw,
  output logic synced
);

  logic meta;

  // NOTE: sequential state uses <= so both flops sample pre-edge values and form a true 2-stage chain.
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/uart_prot_tx_seq.sv
// UART protocol-layer TX sequencer: address frames, bounded data frames, optional checksum, stop.
// Optional checksum frame enabled by defining UART_PROT_TX_CSUM_EN.
module uart_prot_tx_seq
  import uart_prot_pkg::*;
#(
  parameter int ADDR_FRAMES = 1,
  parameter int MAX_LEN     = 16,
  parameter int DATA_W      = 8
) (
  input  logic              glb_clk,
  input  logic              glb_rstn,
  input  logic              CFG_PROT_ctrl_Txen,
  input  logic              CFG_PROT_ctrl_empty,
  input  logic [DATA_W-1:0] CFG_PROT_tx_data,
  input  logic              USR_PROT_ctrl_cts,
  input  logic              CORE_CFG_r_en,
  output logic              PROT_CORE_ctrl_Txen,
  output logic              PROT_CORE_ctrl_empty,
  output logic [1:0]        PROT_CFG_ctrl_Txsel,
  output logic [1:0]        PROT_CFG_ctrl_addr_idx,
  output logic              PROT_CFG_ctrl_tx_r_en,
  output logic              PROT_CFG_ctrl_tx_rst,
  output logic [DATA_W-1:0] PROT_CFG_csum,
  output logic              PROT_CFG_busy
);

  localparam int               CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_MAX   = CNT_W'(MAX_LEN);
  localparam logic [1:0]       ADDR_LAST = 2'(ADDR_FRAMES - 1);

  state_e           state, state_nxt;
  logic [1:0]       addr_idx, addr_nxt;
  logic [CNT_W-1:0] data_cnt, cnt_nxt;
  logic             cts_s;
  logic             accept;

  uart_cts_sync u_cts_sync (
    .glb_clk  (glb_clk),
    .glb_rstn (glb_rstn),
    .raw      (USR_PROT_ctrl_cts),
    .synced   (cts_s)
  );

`ifdef UART_PROT_TX_CSUM_EN
  logic [DATA_W-1:0] sum, sum_nxt;
`else
  logic unused_tx_data;
  assign unused_tx_data = ^CFG_PROT_tx_data;
`endif

  // Frame valid is kept apart so accept can feed the next-state logic without a loop.
  always_comb begin
    PROT_CORE_ctrl_Txen = 1'b0;
    unique case (state)
      ST_ADDR, ST_CSUM, ST_STOP: PROT_CORE_ctrl_Txen = cts_s;
      ST_DATA: PROT_CORE_ctrl_Txen = cts_s & ~CFG_PROT_ctrl_empty & (data_cnt < LEN_MAX);
      default: PROT_CORE_ctrl_Txen = 1'b0;
    endcase
  end

  assign accept        = PROT_CORE_ctrl_Txen & CORE_CFG_r_en;
  assign PROT_CFG_busy = (state != ST_IDLE);

  // NOTE: every output and next-state value gets a default first, so no branch can infer a latch.
  always_comb begin
    state_nxt              = state;
    addr_nxt               = addr_idx;
    cnt_nxt                = data_cnt;
`ifdef UART_PROT_TX_CSUM_EN
    sum_nxt                = sum;
`endif
    PROT_CFG_ctrl_Txsel    = TXSEL_ADDR;
    PROT_CFG_ctrl_addr_idx = 2'd0;
    PROT_CFG_ctrl_tx_r_en  = 1'b0;
    PROT_CFG_ctrl_tx_rst   = 1'b0;
    PROT_CORE_ctrl_empty   = 1'b0;
    PROT_CFG_csum          = '0;
    unique case (state)
      ST_IDLE: begin
        if (CFG_PROT_ctrl_Txen) begin
          state_nxt = ST_ADDR;
          addr_nxt  = 2'd0;
          cnt_nxt   = '0;
`ifdef UART_PROT_TX_CSUM_EN
          sum_nxt   = '0;
`endif
        end
      end
      ST_ADDR: begin
        PROT_CFG_ctrl_addr_idx = addr_idx;
        if (accept) begin
          if (addr_idx == ADDR_LAST) state_nxt = ST_DATA;
          else                       addr_nxt  = addr_idx + 2'd1;
        end
      end
      ST_DATA: begin
        PROT_CFG_ctrl_Txsel = TXSEL_DATA;
        if (accept) begin
          PROT_CFG_ctrl_tx_r_en = 1'b1;
          cnt_nxt               = data_cnt + 1'b1;
`ifdef UART_PROT_TX_CSUM_EN
          sum_nxt               = sum + CFG_PROT_tx_data;
`endif
        end else if (CFG_PROT_ctrl_empty || data_cnt == LEN_MAX) begin
`ifdef UART_PROT_TX_CSUM_EN
          state_nxt = ST_CSUM;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_PROT_TX_CSUM_EN
      ST_CSUM: begin
        PROT_CFG_ctrl_Txsel = TXSEL_CSUM;
        PROT_CFG_csum       = ~sum + 1'b1;
        if (accept) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        PROT_CFG_ctrl_Txsel = TXSEL_STOP;
        if (accept) begin
          PROT_CORE_ctrl_empty = 1'b1;
          // A truncated packet leaves its remaining words in the FIFO.
          PROT_CFG_ctrl_tx_rst = CFG_PROT_ctrl_empty;
          state_nxt            = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      state    <= ST_IDLE;
      addr_idx <= 2'd0;
      data_cnt <= '0;
    end else begin
      state    <= state_nxt;
      addr_idx <= addr_nxt;
      data_cnt <= cnt_nxt;
    end
  end

`ifdef UART_PROT_TX_CSUM_EN
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) sum <= '0;
    else           sum <= sum_nxt;
  end
`endif

endmodule
